// File: rtl/alarm_sequencer_if.sv
// rtl/alarm_sequencer_if.sv - alarm sequencer signal bundle: timing/trigger inputs and buzzer/indicator outputs
interface alarm_sequencer_if;
    logic tick_en;
    logic timer_done;
    logic ack;
    logic buzzer;
    logic alarm_active;
    logic alarm_led;

    modport master (
        output tick_en,
        output timer_done,
        output ack,
        input  buzzer,
        input  alarm_active,
        input  alarm_led
    );

    modport slave (
        input  tick_en,
        input  timer_done,
        input  ack,
        output buzzer,
        output alarm_active,
        output alarm_led
    );
endinterface

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - turns the countdown-complete level into a repeating buzzer burst pattern
module alarm_sequencer #(
    parameter int BEEP_ON_TICKS   = 25,
    parameter int BEEP_OFF_TICKS  = 25,
    parameter int BEEPS_PER_BURST = 3,
    parameter int BURST_GAP_TICKS = 100,
    parameter int MAX_BURSTS      = 20,
    parameter int TICK_W          = 8,
    parameter int BURST_W         = 5
) (
    input  logic               clk,
    input  logic               reset,
    alarm_sequencer_if.slave   bus
);
    localparam int BEEP_W = (BEEPS_PER_BURST > 1) ? $clog2(BEEPS_PER_BURST) : 1;

    localparam logic [TICK_W-1:0]  ON_LAST    = TICK_W'(BEEP_ON_TICKS - 1);
    localparam logic [TICK_W-1:0]  OFF_LAST   = TICK_W'(BEEP_OFF_TICKS - 1);
    localparam logic [TICK_W-1:0]  GAP_LAST   = TICK_W'(BURST_GAP_TICKS - 1);
    localparam logic [BEEP_W-1:0]  BEEP_LAST  = BEEP_W'(BEEPS_PER_BURST - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURSTS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEEP,
        ST_SPACE,
        ST_GAP,
        ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BEEP_W-1:0]  beep_cnt_q, beep_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               done_q;
    logic               ack_q;
    logic               buzzer_q, buzzer_d;
    logic               active_q;
    logic               led_q;

    logic               rise;
    logic               ack_edge;
    logic               in_alarm;
    logic [TICK_W-1:0]  cur_last;
    logic               tick_done;

    assign rise     = bus.timer_done & ~done_q;
    assign ack_edge = bus.ack & ~ack_q;
    assign in_alarm = (state_q == ST_BEEP) || (state_q == ST_SPACE) || (state_q == ST_GAP);

    always_comb begin
        cur_last = '0;
        unique case (state_q)
            ST_BEEP:  cur_last = ON_LAST;
            ST_SPACE: cur_last = OFF_LAST;
            ST_GAP:   cur_last = GAP_LAST;
            default:  cur_last = '0;
        endcase
    end

    // Terminal compare is exact so a mis-sized counter shows up as a missed end, not a clamp.
    assign tick_done = in_alarm && bus.tick_en && (tick_cnt_q == cur_last);

    always_comb begin
        state_d     = state_q;
        beep_cnt_d  = beep_cnt_q;
        burst_cnt_d = burst_cnt_q;

        if (in_alarm && !bus.timer_done) begin
            state_d = ST_IDLE;
        end else if (in_alarm && ack_edge) begin
            state_d = ST_HOLD;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d     = ack_edge ? ST_HOLD : ST_BEEP;
                        beep_cnt_d  = '0;
                        burst_cnt_d = '0;
                    end
                end
                ST_BEEP: begin
                    if (tick_done) begin
                        if (beep_cnt_q == BEEP_LAST) begin
                            state_d = ST_GAP;
                        end else begin
                            beep_cnt_d = beep_cnt_q + 1'b1;
                            state_d    = ST_SPACE;
                        end
                    end
                end
                ST_SPACE: begin
                    if (tick_done) begin
                        state_d = ST_BEEP;
                    end
                end
                ST_GAP: begin
                    if (tick_done) begin
                        if (burst_cnt_q == BURST_LAST) begin
                            state_d = ST_HOLD;
                        end else begin
                            burst_cnt_d = burst_cnt_q + 1'b1;
                            beep_cnt_d  = '0;
                            state_d     = ST_BEEP;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!bus.timer_done) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (state_d != state_q) begin
            tick_cnt_d = '0;
        end else if (in_alarm && bus.tick_en) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    // Tone restarts high on every BEEP entry so each beep has the same phase.
    always_comb begin
        buzzer_d = 1'b0;
        if (state_d == ST_BEEP) begin
            buzzer_d = (state_q == ST_BEEP) ? ~buzzer_q : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            beep_cnt_q  <= '0;
            burst_cnt_q <= '0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            buzzer_q    <= 1'b0;
            active_q    <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            beep_cnt_q  <= beep_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            done_q      <= bus.timer_done;
            ack_q       <= bus.ack;
            buzzer_q    <= buzzer_d;
            active_q    <= (state_d == ST_BEEP) || (state_d == ST_SPACE) || (state_d == ST_GAP);
            led_q       <= (state_d == ST_BEEP);
        end
    end

    assign bus.buzzer       = buzzer_q;
    assign bus.alarm_active = active_q;
    assign bus.alarm_led    = led_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - self-checking bench for alarm_sequencer with a segment-timeline model
module tb_alarm_sequencer;
    localparam int ON    = 2;
    localparam int OFF   = 1;
    localparam int BEEPS = 2;
    localparam int GAPT  = 3;
    localparam int MAXB  = 2;

    localparam int K_BEEP  = 0;
    localparam int K_SPACE = 1;
    localparam int K_GAP   = 2;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alarm_sequencer_if bus();

    alarm_sequencer #(
        .BEEP_ON_TICKS  (ON),
        .BEEP_OFF_TICKS (OFF),
        .BEEPS_PER_BURST(BEEPS),
        .BURST_GAP_TICKS(GAPT),
        .MAX_BURSTS     (MAXB),
        .TICK_W         (8),
        .BURST_W        (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Whole alarm laid out as a flat list of segments; elapsed ticks index into it.
    int seg_kind[$];
    int seg_len[$];
    int total_ticks = 0;

    function automatic void build_timeline();
        for (int b = 0; b < MAXB; b++) begin
            for (int i = 0; i < BEEPS; i++) begin
                seg_kind.push_back(K_BEEP);
                seg_len.push_back(ON);
                if (i < BEEPS - 1) begin
                    seg_kind.push_back(K_SPACE);
                    seg_len.push_back(OFF);
                end
            end
            seg_kind.push_back(K_GAP);
            seg_len.push_back(GAPT);
        end
        total_ticks = 0;
        foreach (seg_len[i]) total_ticks += seg_len[i];
    endfunction

    function automatic int seg_of(input int el);
        int acc = 0;
        foreach (seg_len[i]) begin
            acc += seg_len[i];
            if (el < acc) return i;
        end
        return seg_len.size() - 1;
    endfunction

    int m_mode = M_IDLE;
    int m_pd = 0;
    int m_pa = 0;
    int m_el = 0;
    int m_seg = 0;
    int m_cyc = 0;

    task automatic model_step();
        int rise;
        int ae;
        int ns;
        rise = (bus.timer_done && !m_pd) ? 1 : 0;
        ae   = (bus.ack && !m_pa) ? 1 : 0;
        if (reset) begin
            m_mode = M_IDLE;
            m_pd   = 0;
            m_pa   = 0;
        end else begin
            m_pd = bus.timer_done;
            m_pa = bus.ack;
            case (m_mode)
                M_IDLE: begin
                    if (rise != 0) begin
                        if (ae != 0) m_mode = M_HOLD;
                        else begin
                            m_mode = M_RUN;
                            m_el = 0;
                            m_seg = 0;
                            m_cyc = 0;
                        end
                    end
                end
                M_RUN: begin
                    if (!bus.timer_done) m_mode = M_IDLE;
                    else if (ae != 0) m_mode = M_HOLD;
                    else if (bus.tick_en) begin
                        m_el++;
                        if (m_el == total_ticks) m_mode = M_HOLD;
                        else begin
                            ns = seg_of(m_el);
                            if (ns != m_seg) m_cyc = 0;
                            else m_cyc++;
                            m_seg = ns;
                        end
                    end else begin
                        m_cyc++;
                    end
                end
                default: begin
                    if (!bus.timer_done) m_mode = M_IDLE;
                end
            endcase
        end
    endtask

    function automatic int exp_active();
        return (m_mode == M_RUN) ? 1 : 0;
    endfunction

    function automatic int exp_led();
        return (m_mode == M_RUN && seg_kind[m_seg] == K_BEEP) ? 1 : 0;
    endfunction

    function automatic int exp_buzzer();
        return (exp_led() == 1 && (m_cyc % 2) == 0) ? 1 : 0;
    endfunction

    logic gate = 1'b1;
    int   tcnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            bus.tick_en = gate && ((tcnt % 10) == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("buzzer", int'(bus.buzzer), exp_buzzer());
            check("alarm_active", int'(bus.alarm_active), exp_active());
            check("alarm_led", int'(bus.alarm_led), exp_led());
        end
    end

    int tick_act = 0;
    int led_rise = 0;
    logic prev_led = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.alarm_active && bus.tick_en) tick_act++;
            if (bus.alarm_led && !prev_led) led_rise++;
            prev_led = bus.alarm_led;
        end
    end

    task automatic clear_counts();
        tick_act = 0;
        led_rise = 0;
    endtask

    task automatic wait_inactive(input int budget, input string name);
        int n = 0;
        while (bus.alarm_active && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.alarm_active) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_kind(input int kind, input int budget, input string name);
        int n = 0;
        while (!(m_mode == M_RUN && seg_kind[m_seg] == kind) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(m_mode == M_RUN && seg_kind[m_seg] == kind)) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic count_active(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.alarm_active) cnt++;
        end
    endtask

    initial begin
        int cnt;
        int leds;
        int toggles;
        logic pb;

        build_timeline();
        bus.tick_en    = 1'b0;
        bus.timer_done = 1'b0;
        bus.ack        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_buzzer", int'(bus.buzzer), 0);
        check("reset_active", int'(bus.alarm_active), 0);
        check("reset_led", int'(bus.alarm_led), 0);
        check("timeline_total", total_ticks, 16);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 1: full pattern then HOLD
        clear_counts();
        bus.timer_done = 1'b1;
        @(negedge clk);
        check("t1_active_next", int'(bus.alarm_active), 1);
        check("t1_buzzer_first", int'(bus.buzzer), 1);
        @(negedge clk);
        check("t1_buzzer_second", int'(bus.buzzer), 0);
        wait_inactive(400, "t1");
        check("t1_ticks_active", tick_act, 16);
        check("t1_beeps", led_rise, 4);
        count_active(30, cnt);
        check("t1_hold_silent", cnt, 0);
        bus.timer_done = 1'b0;
        repeat (5) @(negedge clk);

        // 2: ack edge mid-BEEP
        bus.timer_done = 1'b1;
        wait_kind(K_BEEP, 50, "t2");
        repeat (2) @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        check("t2_ack_buzzer", int'(bus.buzzer), 0);
        check("t2_ack_active", int'(bus.alarm_active), 0);
        count_active(20, cnt);
        bus.ack = 1'b0;
        repeat (3) @(negedge clk);
        bus.ack = 1'b1;
        count_active(20, leds);
        check("t2_no_restart", cnt + leds, 0);
        bus.timer_done = 1'b0;
        bus.ack = 1'b0;
        repeat (5) @(negedge clk);

        // 3: timer_done drops mid-GAP, then a fresh full alarm
        bus.timer_done = 1'b1;
        wait_kind(K_GAP, 200, "t3");
        @(negedge clk);
        bus.timer_done = 1'b0;
        @(negedge clk);
        check("t3_drop_active", int'(bus.alarm_active), 0);
        repeat (5) @(negedge clk);
        clear_counts();
        bus.timer_done = 1'b1;
        @(negedge clk);
        wait_inactive(400, "t3b");
        check("t3_ticks_active", tick_act, 16);
        check("t3_beeps", led_rise, 4);
        bus.timer_done = 1'b0;
        repeat (5) @(negedge clk);

        // 4: rise and ack edge together
        bus.timer_done = 1'b1;
        bus.ack = 1'b1;
        count_active(50, cnt);
        check("t4_never_active", cnt, 0);
        bus.timer_done = 1'b0;
        bus.ack = 1'b0;
        repeat (3) @(negedge clk);
        clear_counts();
        bus.timer_done = 1'b1;
        @(negedge clk);
        check("t4_restart_active", int'(bus.alarm_active), 1);
        wait_inactive(400, "t4");
        check("t4_ticks_active", tick_act, 16);
        bus.timer_done = 1'b0;
        repeat (5) @(negedge clk);

        // 5: reset mid-SPACE with timer_done held high
        bus.timer_done = 1'b1;
        wait_kind(K_SPACE, 200, "t5");
        reset = 1'b1;
        @(negedge clk);
        check("t5_reset_buzzer", int'(bus.buzzer), 0);
        check("t5_reset_active", int'(bus.alarm_active), 0);
        check("t5_reset_led", int'(bus.alarm_led), 0);
        clear_counts();
        reset = 1'b0;
        @(negedge clk);
        check("t5_rearm_active", int'(bus.alarm_active), 1);
        check("t5_rearm_buzzer", int'(bus.buzzer), 1);
        wait_inactive(400, "t5");
        check("t5_ticks_active", tick_act, 16);
        check("t5_beeps", led_rise, 4);
        bus.timer_done = 1'b0;
        repeat (5) @(negedge clk);

        // 6: tick_en frozen mid-BEEP
        clear_counts();
        bus.timer_done = 1'b1;
        @(negedge clk);
        gate = 1'b0;
        leds = 0;
        toggles = 0;
        pb = bus.buzzer;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.alarm_led) leds++;
            if (i > 0 && bus.buzzer != pb) toggles++;
            pb = bus.buzzer;
        end
        check("t6_frozen_led", leds, 500);
        check("t6_toggles", toggles, 499);
        gate = 1'b1;
        wait_inactive(400, "t6");
        check("t6_ticks_active", tick_act, 16);
        check("t6_beeps", led_rise, 4);
        bus.timer_done = 1'b0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
